// File: rtl/adc_phs_cal_if.sv
// Handshake and status bundle between the phase calibration sequencer and its
// software register / capture delay neighbours.
interface adc_phs_cal_if #(
    parameter int unsigned PHS_W = 5,
    parameter int unsigned ERR_W = 16
);
    logic             start;
    logic             sw_override;
    logic [PHS_W-1:0] sw_phs;
    logic             pat_err;
    logic [31:0]      phs_out;
    logic             phs_load;
    logic             busy;
    logic             done;
    logic             cal_ok;
    logic [PHS_W-1:0] win_start;
    logic [PHS_W:0]   win_len;
    logic [ERR_W-1:0] err_last;

    modport master (
        output start, sw_override, sw_phs, pat_err,
        input  phs_out, phs_load, busy, done, cal_ok, win_start, win_len, err_last
    );

    modport slave (
        input  start, sw_override, sw_phs, pat_err,
        output phs_out, phs_load, busy, done, cal_ok, win_start, win_len, err_last
    );
endinterface

// File: rtl/adc_phs_cal_ctrl.sv
// ADC capture phase calibration: sweeps every tap, counts pattern errors per tap and
// programs the centre of the longest clean run of taps.
module adc_phs_cal_ctrl #(
    parameter int unsigned PHS_W      = 5,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned WIN_CYC    = 1024,
    parameter int unsigned ERR_W      = 16
) (
    input logic          OPB_Clk,
    input logic          OPB_Rst,
    adc_phs_cal_if.slave cal
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StSettle  = 3'd2;
    localparam logic [2:0] StMeasure = 3'd3;
    localparam logic [2:0] StEval    = 3'd4;
    localparam logic [2:0] StFinal   = 3'd5;

    localparam int unsigned CNT_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PHS_W-1:0] TAP_LAST    = '1;
    localparam logic [PHS_W-1:0] TAP_ONE     = PHS_W'(1);
    localparam logic [PHS_W:0]   LEN_ONE     = (PHS_W + 1)'(1);
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    logic [2:0]       state_q, state_d;
    logic [PHS_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [PHS_W:0]   run_len_q, run_len_d;
    logic [PHS_W-1:0] run_start_q, run_start_d;
    logic [PHS_W:0]   best_len_q, best_len_d;
    logic [PHS_W-1:0] best_start_q, best_start_d;
    logic [PHS_W-1:0] saved_q, saved_d;
    logic [PHS_W-1:0] phs_q, phs_d;
    logic             phs_load_q, phs_load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cal_ok_q, cal_ok_d;
    logic [PHS_W-1:0] win_start_q, win_start_d;
    logic [PHS_W:0]   win_len_q, win_len_d;
    logic [ERR_W-1:0] err_last_q, err_last_d;

    // Run/best bookkeeping as it would stand after the current EVAL.
    logic             clean;
    logic             best_upd;
    logic [PHS_W:0]   run_len_nx, best_len_nx, len_m1;
    logic [PHS_W-1:0] run_start_nx, best_start_nx, centre;

    always_comb begin
        clean         = (err_q == '0);
        run_len_nx    = clean ? run_len_q + LEN_ONE : '0;
        run_start_nx  = (clean && run_len_q == '0) ? tap_q : run_start_q;
        best_upd      = run_len_nx > best_len_q;
        best_len_nx   = best_upd ? run_len_nx : best_len_q;
        best_start_nx = best_upd ? run_start_nx : best_start_q;
        len_m1        = best_len_nx - LEN_ONE;
        centre        = best_start_nx + len_m1[PHS_W:1];
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        saved_d      = saved_q;
        phs_d        = phs_q;
        phs_load_d   = 1'b0;
        done_d       = 1'b0;
        cal_ok_d     = cal_ok_q;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        err_last_d   = err_last_q;

        case (state_q)
            StIdle: begin
                if (cal.start) begin
                    state_d      = StLoad;
                    tap_d        = '0;
                    cnt_d        = '0;
                    run_len_d    = '0;
                    run_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    saved_d      = phs_q;
                    phs_d        = '0;
                    phs_load_d   = 1'b1;
                end else if (cal.sw_override && cal.sw_phs != phs_q) begin
                    phs_d      = cal.sw_phs;
                    phs_load_d = 1'b1;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = StMeasure;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StMeasure: begin
                if (cal.pat_err && err_q != '1) err_d = err_q + ERR_ONE;
                if (cnt_q == WIN_LAST) begin
                    cnt_d   = '0;
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StEval: begin
                err_last_d   = err_q;
                run_len_d    = run_len_nx;
                run_start_d  = run_start_nx;
                best_len_d   = best_len_nx;
                best_start_d = best_start_nx;
                phs_load_d   = 1'b1;
                if (tap_q == TAP_LAST) begin
                    state_d     = StFinal;
                    done_d      = 1'b1;
                    win_start_d = best_start_nx;
                    win_len_d   = best_len_nx;
                    if (best_len_nx != '0) begin
                        phs_d    = centre;
                        cal_ok_d = 1'b1;
                    end else begin
                        phs_d    = saved_q;
                        cal_ok_d = 1'b0;
                    end
                end else begin
                    tap_d   = tap_q + TAP_ONE;
                    phs_d   = tap_q + TAP_ONE;
                    state_d = StLoad;
                end
            end
            StFinal: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q      <= StIdle;
            tap_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            saved_q      <= '0;
            phs_q        <= '0;
            phs_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cal_ok_q     <= 1'b0;
            win_start_q  <= '0;
            win_len_q    <= '0;
            err_last_q   <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            saved_q      <= saved_d;
            phs_q        <= phs_d;
            phs_load_q   <= phs_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cal_ok_q     <= cal_ok_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
            err_last_q   <= err_last_d;
        end
    end

    assign cal.phs_out   = 32'(phs_q);
    assign cal.phs_load  = phs_load_q;
    assign cal.busy      = busy_q;
    assign cal.done      = done_q;
    assign cal.cal_ok    = cal_ok_q;
    assign cal.win_start = win_start_q;
    assign cal.win_len   = win_len_q;
    assign cal.err_last  = err_last_q;
endmodule

// File: tb/tb_adc_phs_cal_ctrl.sv
// Bench for adc_phs_cal_ctrl: directed vector table, hand sequences for override, reset
// and saturation, then random sweeps checked against a clean-run search model.
module tb_adc_phs_cal_ctrl;
    localparam int unsigned PW = 3;
    localparam int unsigned SC = 4;
    localparam int unsigned WC = 8;
    localparam int unsigned EW = 4;
    localparam int unsigned WC_SAT = 20;
    localparam int NT    = 8;
    localparam int P     = SC + WC + 2;
    localparam int TOTAL = NT * P + 1;

    logic clk;
    logic rst;

    adc_phs_cal_if #(.PHS_W(PW), .ERR_W(EW)) m ();
    adc_phs_cal_if #(.PHS_W(PW), .ERR_W(EW)) s ();

    adc_phs_cal_ctrl #(.PHS_W(PW), .SETTLE_CYC(SC), .WIN_CYC(WC), .ERR_W(EW)) u_dut (
        .OPB_Clk(clk),
        .OPB_Rst(rst),
        .cal    (m.slave)
    );

    adc_phs_cal_ctrl #(.PHS_W(PW), .SETTLE_CYC(SC), .WIN_CYC(WC_SAT), .ERR_W(EW)) u_sat (
        .OPB_Clk(clk),
        .OPB_Rst(rst),
        .cal    (s.slave)
    );

    typedef struct {
        logic [7:0] dirty;
        bit         noise;
        bit         ok;
        int         ws;
        int         wl;
        int         phs;
        int         el;
    } vec_t;

    vec_t tbl[5];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur_phs = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {m.phs_out, m.phs_load, m.busy, m.done, m.cal_ok, m.win_start, m.win_len,
                     m.err_last}, 64'd0);
    endtask

    // One full calibration. Dirty taps see pat_err with the given density; clean taps see
    // random pat_err only outside their measurement window, which must be ignored.
    task automatic run_sweep(input logic [7:0] dirty, input int dens, input bit noise,
                             input int rst_at, input bit has_exp, input bit e_ok,
                             input int e_ws, input int e_wl, input int e_phs, input int e_el);
        int errs[NT];
        int loads[$];
        int done_c, tap, o, run, rs, bl, bs, saved;
        bit busy_bad;
        logic pe;
        logic [63:0] o_ok, o_ws, o_wl, o_phs, o_el;
        bit x_ok;
        int x_ws, x_wl, x_phs, x_el;
        string tag;

        foreach (errs[k]) errs[k] = 0;
        done_c = -1; busy_bad = 0; saved = cur_phs;
        o_ok = '0; o_ws = '0; o_wl = '0; o_phs = '0; o_el = '0;
        tag = $sformatf("sweep%02h", dirty);
        @(negedge clk);
        m.start = 1'b1; m.sw_override = 1'b0;
        @(negedge clk);
        m.start = 1'b0;
        for (int c = 1; c <= TOTAL + 1; c++) begin
            if (rst_at > 0 && c == rst_at) begin
                rst = 1'b1;
                #1 check_zero("rst_async");
                @(negedge clk) check_zero("rst_hold");
                rst = 1'b0;
                @(negedge clk) check_zero("rst_idle");
                cur_phs = 0;
                return;
            end
            if (m.phs_load) loads.push_back(int'(m.phs_out));
            if (m.done && done_c < 0) begin
                done_c = c;
                o_ok = 64'(m.cal_ok); o_ws = 64'(m.win_start); o_wl = 64'(m.win_len);
                o_phs = 64'(m.phs_out); o_el = 64'(m.err_last);
            end
            if (c <= TOTAL && !m.busy) busy_bad = 1;
            if (c == TOTAL + 1) begin
                check({tag, "_idle_after"}, {m.busy, m.done, m.phs_load}, 64'd0);
            end
            pe = 1'b0;
            if (c < TOTAL) begin
                tap = (c - 1) / P;
                o = (c - 1) % P;
                if (dirty[tap]) pe = (dens >= 100) ? 1'b1 : ($urandom_range(99) < dens);
                else if (o < SC + 1 || o > SC + WC) pe = 1'($urandom);
                if (o >= SC + 1 && o <= SC + WC) errs[tap] += int'(pe);
            end
            m.pat_err = pe;
            if (noise && c < TOTAL) begin
                m.start = 1'($urandom); m.sw_override = 1'b1; m.sw_phs = PW'($urandom);
            end else begin
                m.start = 1'b0; m.sw_override = 1'b0;
            end
            if (c <= TOTAL) @(negedge clk);
        end

        // Model: longest run of zero-error taps, lowest tap on a tie, no wrap.
        run = 0; rs = 0; bl = 0; bs = 0;
        for (int k = 0; k < NT; k++) begin
            if (errs[k] == 0) begin
                if (run == 0) rs = k;
                run++;
                if (run > bl) begin bl = run; bs = rs; end
            end else run = 0;
        end
        if (has_exp) begin
            x_ok = e_ok; x_ws = e_ws; x_wl = e_wl; x_phs = e_phs; x_el = e_el;
        end else begin
            x_ok = (bl > 0); x_ws = bs; x_wl = bl;
            x_phs = (bl > 0) ? bs + (bl - 1) / 2 : saved;
            x_el = (errs[NT-1] > 15) ? 15 : errs[NT-1];
        end

        check({tag, "_done_cycle"}, 64'(done_c), 64'(TOTAL));
        check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
        check({tag, "_cal_ok"}, o_ok, 64'(x_ok));
        check({tag, "_win_start"}, o_ws, 64'(x_ws));
        check({tag, "_win_len"}, o_wl, 64'(x_wl));
        check({tag, "_phs_final"}, o_phs, 64'(x_phs));
        check({tag, "_err_last"}, o_el, 64'(x_el));
        check({tag, "_load_count"}, 64'(loads.size()), 64'(NT + 1));
        for (int k = 0; k < loads.size() && k <= NT; k++)
            check($sformatf("%s_load%0d", tag, k), 64'(loads[k]), 64'((k < NT) ? k : x_phs));
        cur_phs = x_phs;
    endtask

    initial begin
        int c;
        clk = 1'b0; rst = 1'b1;
        m.start = 1'b0; m.sw_override = 1'b0; m.sw_phs = '0; m.pat_err = 1'b0;
        s.start = 1'b0; s.sw_override = 1'b0; s.sw_phs = '0; s.pat_err = 1'b1;

        tbl[0] = '{8'b1100_0011, 1'b0, 1'b1, 2, 4, 3, 8};
        tbl[1] = '{8'b1001_1100, 1'b0, 1'b1, 0, 2, 0, 8};
        tbl[2] = '{8'b0111_1110, 1'b0, 1'b1, 0, 1, 0, 0};
        tbl[3] = '{8'b0000_0000, 1'b1, 1'b1, 0, 8, 3, 0};
        tbl[4] = '{8'b1100_0011, 1'b1, 1'b1, 2, 4, 3, 8};

        repeat (3) @(negedge clk);
        check_zero("reset_values");
        rst = 1'b0;
        @(negedge clk) check_zero("idle_after_reset");

        for (int i = 0; i < 5; i++)
            run_sweep(tbl[i].dirty, 100, tbl[i].noise, 0, 1'b1, tbl[i].ok, tbl[i].ws,
                      tbl[i].wl, tbl[i].phs, tbl[i].el);

        // Override path: one strobe per change, none while value already matches.
        m.sw_override = 1'b1; m.sw_phs = 3'd6;
        @(negedge clk);
        check("ovr_phs6", 64'(m.phs_out), 64'd6);
        check("ovr_load6", 64'(m.phs_load), 64'd1);
        @(negedge clk);
        check("ovr_single_load", 64'(m.phs_load), 64'd0);
        m.sw_phs = 3'd5;
        @(negedge clk);
        check("ovr_phs5", {m.phs_out, m.phs_load}, {32'd5, 1'b1});
        m.sw_override = 1'b0;
        cur_phs = 5;

        // All taps dirty: falls back to the pre-start phase.
        run_sweep(8'hFF, 100, 1'b0, 0, 1'b1, 1'b0, 0, 0, 5, 8);

        // Reset during MEASURE of tap 4, then a clean full sweep from tap 0.
        run_sweep(8'hFF, 100, 1'b0, 1 + 4 * P + SC + 3, 1'b0, 1'b0, 0, 0, 0, 0);
        run_sweep(8'b1100_0011, 100, 1'b0, 0, 1'b1, 1'b1, 2, 4, 3, 8);

        // Saturating error counter with a window longer than 2^ERR_W-1.
        @(negedge clk) s.start = 1'b1;
        @(negedge clk) s.start = 1'b0;
        c = 1;
        while (!s.done && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("sat_done_cycle", 64'(c), 64'(NT * (SC + WC_SAT + 2) + 1));
        check("sat_err_last", 64'(s.err_last), 64'd15);
        check("sat_cal_ok", 64'(s.cal_ok), 64'd0);
        check("sat_phs_final", {s.phs_out, s.phs_load}, {32'd0, 1'b1});

        for (int i = 0; i < 8; i++)
            run_sweep(8'($urandom), int'($urandom_range(60, 5)), 1'($urandom), 0, 1'b0,
                      1'b0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_phs_cal_ctrl.md
# adc_phs_cal_ctrl

Sequencer that calibrates the ADC input capture phase. On `start` it sweeps every phase tap and waits for the capture to settle at each one. It then counts test-pattern mismatches over a fixed window and programs the centre of the longest error-free run of taps. In the XPS system it sits between the ADC input phase software register and the ADC capture delay logic. Software can still force a phase directly when the sequencer is idle.

## Interface
Parameters:
- `PHS_W`, 5 — phase tap width; taps 0..2^PHS_W-1.
- `SETTLE_CYC`, 64 — cycles waited after each phase load before measuring (≥1).
- `WIN_CYC`, 1024 — measurement window length in cycles (≥1).
- `ERR_W`, 16 — error counter width; the counter saturates.

Ports:
- `OPB_Clk`  in  1  — sole clock.
- `OPB_Rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — one-cycle request to run calibration; honoured only in IDLE.
- `sw_override`  in  1  — level; while in IDLE, `phs_out` follows `sw_phs`.
- `sw_phs`  in  PHS_W  — software phase value, e.g. from the software register `user_data_out[PHS_W-1:0]`.
- `pat_err`  in  1  — per-cycle test-pattern mismatch flag, already synchronous to `OPB_Clk`.
- `phs_out`  out  32  — phase sent to the capture delay logic; zero-extended from PHS_W bits.
- `phs_load`  out  1  — one-cycle strobe whenever `phs_out` takes a new value.
- `busy`  out  1  — high from LOAD through FINAL inclusive.
- `done`  out  1  — one-cycle pulse when calibration completes.
- `cal_ok`  out  1  — result of the last calibration: 1 if at least one clean tap was found.
- `win_start`  out  PHS_W  — first tap of the best clean run.
- `win_len`  out  PHS_W+1  — length of the best clean run (0..2^PHS_W).
- `err_last`  out  ERR_W  — error count of the most recently measured tap.

## Operation
States: IDLE, LOAD, SETTLE, MEASURE, EVAL, FINAL.

- **IDLE**
  - `start`=1 → LOAD with tap=0 and run/best registers cleared. `start` has priority over `sw_override`.
  - Otherwise, if `sw_override`=1 and `sw_phs` ≠ `phs_out`: `phs_out`←`sw_phs` and `phs_load` pulses.
- **LOAD** (1 cycle): `phs_out`←tap, `phs_load`=1, settle counter cleared → SETTLE.
- **SETTLE**: waits SETTLE_CYC cycles, then clears the error counter → MEASURE.
- **MEASURE**: WIN_CYC cycles; each cycle with `pat_err`=1 increments the error counter, saturating at 2^ERR_W-1.
- **EVAL** (1 cycle): `err_last`←count.
  - count==0: run_len+1; run_start←tap if run_len was 0.
  - count≠0: run_len←0.
  - Best update: if the new run_len > best_len (strictly greater, so the lower tap wins a tie), best_start←run_start and best_len←run_len.
  - tap==2^PHS_W-1 → FINAL; else tap+1 → LOAD.
  - No wrap-around: taps 2^PHS_W-1 and 0 are not adjacent.
- **FINAL** (1 cycle):
  - best_len>0: `phs_out`←best_start+((best_len-1)>>1), computed at PHS_W bits with no overflow possible; `cal_ok`←1.
  - best_len==0: `phs_out`←the value held before `start`; `cal_ok`←0.
  - In both cases: `phs_load`=1, `done`=1, `win_start`/`win_len` updated → IDLE.
- `start`, `sw_override` and `sw_phs` are ignored while `busy`.
- **Reset** (any state, including mid-sweep): immediately IDLE, `phs_out`=0, `phs_load`=0, `busy`=0, `done`=0, `cal_ok`=0, `win_start`=0, `win_len`=0, `err_last`=0, all counters 0.
  - No `phs_load` strobe is issued on reset; downstream logic resets to 0 on its own.

## Timing
- All outputs are registered.
- `start` sampled high in cycle T → `busy`=1 and `phs_load`=1 with `phs_out`=0 in cycle T+1.
- Per tap: 1 (LOAD) + SETTLE_CYC + WIN_CYC + 1 (EVAL) cycles.
- `pat_err` is counted in exactly the WIN_CYC MEASURE cycles; values in SETTLE, EVAL and LOAD are ignored.
- FINAL follows the last EVAL; `done` and the final `phs_load` assert in that same cycle; `busy` drops the next cycle.
- Total calibration: 2^PHS_W·(SETTLE_CYC+WIN_CYC+2)+1 cycles from `start` to `done`.
- Override path: `sw_phs` change in cycle T → `phs_out` and `phs_load` in cycle T+1.

## Test plan
(PHS_W=3, SETTLE_CYC=4, WIN_CYC=8, ERR_W=4 unless stated.)
1. **Reset values:** assert `OPB_Rst` → every output 0. Pulse `start` → `phs_load` seen for taps 0..7 in order; `done` exactly 113 cycles after `start`.
2. **Single clean run:** `pat_err` high only while `phs_out` ∈ {0,1,6,7} → `win_start`=2, `win_len`=4, `cal_ok`=1, final `phs_out`=3.
3. **Tie and no wrap:** clean taps {0,1} and {5,6} with 7 dirty → `win_start`=0, `win_len`=2, final `phs_out`=0.
   - Clean {0,7} only → `win_len`=1, `win_start`=0.
4. **All dirty and saturation:** `pat_err` held at 1 with `phs_out`=5 set by override beforehand → `err_last`=8.
   - With WIN_CYC=20 → `err_last`=15.
   - `cal_ok`=0; final `phs_out`=5 with a `phs_load` pulse.
5. **Override and busy masking:** in IDLE, `sw_override`=1 and `sw_phs`=6 → `phs_out`=6 one cycle later with a single `phs_load`.
   - During a sweep, toggling `sw_phs` and pulsing `start` again have no effect on the tap sequence.
6. **Reset mid-operation:** assert `OPB_Rst` during MEASURE of tap 4 → next cycle IDLE with all outputs 0.
   - A subsequent `start` runs the full sweep from tap 0.
